// File: rtl/regfile_pkg.sv
// Shared constants and typedefs for the register-file operand stage.
// Widths here are the defaults; parametrised instances size their own signals.
package regfile_pkg;

  localparam int unsigned DefaultWidth   = 16;
  localparam int unsigned DefaultNregs   = 8;
  localparam int unsigned DefaultAw      = $clog2(DefaultNregs);
  localparam bit          DefaultZeroReg = 1'b0;

  typedef struct packed {
    logic [DefaultAw-1:0] rs_a;
    logic [DefaultAw-1:0] rs_b;
    logic [DefaultAw-1:0] rd;
    logic                 wr_en;
  } req_t;

  typedef struct packed {
    logic [DefaultWidth-1:0] a;
    logic [DefaultWidth-1:0] b;
    logic [DefaultAw-1:0]    rd;
    logic                    wr_en;
  } out_t;

endpackage

// File: rtl/regfile_operand_stage_if.sv
// Request, writeback and ALU-output bundle of the operand stage.
// The master side is decode/writeback/consumer; the slave side is the stage itself.
interface regfile_operand_stage_if #(
  parameter int unsigned WIDTH = regfile_pkg::DefaultWidth,
  parameter int unsigned AW    = regfile_pkg::DefaultAw
);

  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_rs_a;
  logic [AW-1:0]    req_rs_b;
  logic [AW-1:0]    req_rd;
  logic             req_wr_en;

  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [AW-1:0]    out_rd;
  logic             out_wr_en;

  modport master (
    output req_valid, req_rs_a, req_rs_b, req_rd, req_wr_en,
    output wb_valid, wb_addr, wb_data,
    output out_ready,
    input  req_ready, out_valid, A, B, out_rd, out_wr_en
  );

  modport slave (
    input  req_valid, req_rs_a, req_rs_b, req_rd, req_wr_en,
    input  wb_valid, wb_addr, wb_data,
    input  out_ready,
    output req_ready, out_valid, A, B, out_rd, out_wr_en
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy bit per register: set on issue of a writing instruction, cleared on writeback.
// A set and a clear of the same address in one cycle leaves the bit set.
module reg_scoreboard #(
  parameter int unsigned NREGS = regfile_pkg::DefaultNregs,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] query_a,
  input  logic [AW-1:0] query_b,
  input  logic [AW-1:0] query_rd,
  output logic          busy_a,
  output logic          busy_b,
  output logic          busy_rd
);

  logic [NREGS-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_a  = busy_q[query_a];
  assign busy_b  = busy_q[query_b];
  assign busy_rd = busy_q[query_rd];

endmodule

// File: rtl/regfile_operand_stage.sv
// Two-read register file with writeback forwarding, busy scoreboard and a
// single-entry valid/ready output register feeding the ALU.
module regfile_operand_stage
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned NREGS    = DefaultNregs,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter bit          ZERO_REG = DefaultZeroReg
) (
  input logic                     clk,
  input logic                     reset,
  regfile_operand_stage_if.slave  bus
);

  logic [WIDTH-1:0] regs_q [NREGS];

  logic [WIDTH-1:0] a_q, b_q;
  logic [AW-1:0]    rd_q;
  logic             wr_en_q, out_valid_q;

  logic [WIDTH-1:0] src_a, src_b;
  logic             wb_hit_a, wb_hit_b, wb_hit_rd;
  logic             busy_a, busy_b, busy_rd;
  logic             src_a_rdy, src_b_rdy, dst_free, stage_free;
  logic             accept, set_en, wb_write;

  assign wb_hit_a  = bus.wb_valid && (bus.wb_addr == bus.req_rs_a);
  assign wb_hit_b  = bus.wb_valid && (bus.wb_addr == bus.req_rs_b);
  assign wb_hit_rd = bus.wb_valid && (bus.wb_addr == bus.req_rd);

  // Register 0 is hardwired when ZERO_REG: writes vanish and it never goes busy.
  assign wb_write = bus.wb_valid && !(ZERO_REG && (bus.wb_addr == '0));

  always_comb begin
    src_a = regs_q[bus.req_rs_a];
    if (wb_hit_a) src_a = bus.wb_data;
    if (ZERO_REG && (bus.req_rs_a == '0)) src_a = '0;
  end

  always_comb begin
    src_b = regs_q[bus.req_rs_b];
    if (wb_hit_b) src_b = bus.wb_data;
    if (ZERO_REG && (bus.req_rs_b == '0)) src_b = '0;
  end

  assign src_a_rdy  = !busy_a || wb_hit_a;
  assign src_b_rdy  = !busy_b || wb_hit_b;
  assign dst_free   = !bus.req_wr_en || !busy_rd || wb_hit_rd;
  assign stage_free = !out_valid_q || bus.out_ready;

  assign bus.req_ready = stage_free && src_a_rdy && src_b_rdy && dst_free;
  assign accept        = bus.req_valid && bus.req_ready;
  assign set_en        = accept && bus.req_wr_en && !(ZERO_REG && (bus.req_rd == '0));

  reg_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_addr (bus.req_rd),
    .clr_en   (bus.wb_valid),
    .clr_addr (bus.wb_addr),
    .query_a  (bus.req_rs_a),
    .query_b  (bus.req_rs_b),
    .query_rd (bus.req_rd),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .busy_rd  (busy_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_write) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      wr_en_q     <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      a_q         <= src_a;
      b_q         <= src_b;
      rd_q        <= bus.req_rd;
      wr_en_q     <= bus.req_wr_en;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_wr_en = wr_en_q;

endmodule
